// File: rtl/enigma_rotor_stepper.sv
// Rotor stepping controller for the three-rotor ENIGMA551 datapath: accepts one
// letter at a time, applies notch/double-step rules and presents letter+positions to the chain.
module enigma_rotor_stepper #(
  parameter logic [4:0] NOTCH1 = 5'd21,
  parameter logic [4:0] NOTCH2 = 5'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] load_pos1,
  input  logic [4:0] load_pos2,
  input  logic [4:0] load_pos3,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [4:0] key_in,
  input  logic       chain_done,
  output logic [4:0] pos1,
  output logic [4:0] pos2,
  output logic [4:0] pos3,
  output logic [4:0] key_out,
  output logic       step_valid,
  output logic       err,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [4:0] LETTERS = 5'd26;
  localparam logic [4:0] LAST    = 5'd25;

  state_t     state_q, state_d;
  logic [4:0] pos1_q, pos2_q, pos3_q, key_q;
  logic [4:0] pos1_d, pos2_d, pos3_d, key_d;
  logic       err_q, err_d;

  logic key_ok;
  logic load_bad;
  logic carry2;
  logic carry3;

  function automatic logic [4:0] fold26(input logic [4:0] v);
    return (v >= LETTERS) ? (v - LETTERS) : v;
  endfunction

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v >= LAST) ? 5'd0 : (v + 5'd1);
  endfunction

  assign key_ok   = (key_in < LETTERS);
  assign load_bad = (load_pos1 >= LETTERS) || (load_pos2 >= LETTERS) ||
                    (load_pos3 >= LETTERS);
  // Carries look at the positions held before the step; pos2 at its notch
  // moves both itself (double step) and rotor 3.
  assign carry2   = (pos1_q == NOTCH1) || (pos2_q == NOTCH2);
  assign carry3   = (pos2_q == NOTCH2);

  always_comb begin
    state_d = state_q;
    pos1_d  = pos1_q;
    pos2_d  = pos2_q;
    pos3_d  = pos3_q;
    key_d   = key_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load) begin
          pos1_d = fold26(load_pos1);
          pos2_d = fold26(load_pos2);
          pos3_d = fold26(load_pos3);
          err_d  = load_bad;
        end else if (key_valid) begin
          if (key_ok) begin
            key_d   = key_in;
            state_d = S_STEP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_STEP: begin
        pos1_d  = inc26(pos1_q);
        if (carry2) pos2_d = inc26(pos2_q);
        if (carry3) pos3_d = inc26(pos3_q);
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (chain_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pos1_q  <= 5'd0;
      pos2_q  <= 5'd0;
      pos3_q  <= 5'd0;
      key_q   <= 5'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos1_q  <= pos1_d;
      pos2_q  <= pos2_d;
      pos3_q  <= pos3_d;
      key_q   <= key_d;
      err_q   <= err_d;
    end
  end

  // Handshake: a letter transfers on a rising edge where key_valid && key_ready;
  // key_ready is high only in IDLE without load, and an out-of-range letter is
  // consumed but dropped. Outputs are gated low while rst_n is asserted.
  assign key_ready  = rst_n && (state_q == S_IDLE) && !load;
  assign step_valid = rst_n && (state_q == S_HOLD);
  assign err        = rst_n && err_q;
  assign pos1       = pos1_q;
  assign pos2       = pos2_q;
  assign pos3       = pos3_q;
  assign key_out    = key_q;
  assign state_dbg  = state_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (pos1_q <= LAST);
      assert (pos2_q <= LAST);
      assert (pos3_q <= LAST);
    end
  end

endmodule

// File: tb/tb_enigma_rotor_stepper.sv
// Self-checking bench for enigma_rotor_stepper: directed scenarios plus randomized
// traffic compared against an arithmetic rotor model.
module tb_enigma_rotor_stepper;

  localparam int NOTCH1 = 21;
  localparam int NOTCH2 = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [4:0] load_pos1, load_pos2, load_pos3;
  logic       key_valid;
  logic       key_ready;
  logic [4:0] key_in;
  logic       chain_done;
  logic [4:0] pos1, pos2, pos3;
  logic [4:0] key_out;
  logic       step_valid;
  logic       err;
  logic [1:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  int m_p1, m_p2, m_p3, m_key;
  logic [19:0] exp_q[$];

  enigma_rotor_stepper #(.NOTCH1(5'd21), .NOTCH2(5'd4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .load_pos1(load_pos1), .load_pos2(load_pos2), .load_pos3(load_pos3),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
    .chain_done(chain_done), .pos1(pos1), .pos2(pos2), .pos3(pos3),
    .key_out(key_out), .step_valid(step_valid), .err(err), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic void model_reset();
    m_p1 = 0; m_p2 = 0; m_p3 = 0; m_key = 0;
  endfunction

  function automatic void model_load(input int a, input int b, input int c);
    m_p1 = a % 26; m_p2 = b % 26; m_p3 = c % 26;
  endfunction

  function automatic void model_step();
    bit c2, c3;
    c2 = (m_p1 == NOTCH1) || (m_p2 == NOTCH2);
    c3 = (m_p2 == NOTCH2);
    m_p1 = (m_p1 + 1) % 26;
    if (c2) m_p2 = (m_p2 + 1) % 26;
    if (c3) m_p3 = (m_p3 + 1) % 26;
  endfunction

  function automatic logic [14:0] model_pos();
    return {m_p3[4:0], m_p2[4:0], m_p1[4:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_load(input int a, input int b, input int c);
    load = 1'b1; load_pos1 = a[4:0]; load_pos2 = b[4:0]; load_pos3 = c[4:0];
    tick();
    load = 1'b0;
  endtask

  // Leaves the bench in the first HOLD cycle.
  task automatic drive_accept(input int k);
    key_valid = 1'b1; key_in = k[4:0];
    tick();
    key_valid = 1'b0;
    tick();
  endtask

  task automatic drive_release();
    chain_done = 1'b1;
    tick();
    chain_done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({pos3, pos2, pos1, key_out} !== 20'd0) begin
      failures++; $display("FAIL reset_regs: got %h expected 0", {pos3, pos2, pos1, key_out});
    end
    checks++;
    if ({step_valid, err, key_ready} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got %b expected 000", {step_valid, err, key_ready});
    end
    rst_n = 1'b1; #1;
    checks++;
    if (key_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready: got %b expected 1", key_ready);
    end
    model_reset();
  endtask

  task automatic test_basic_step();
    key_in = 5'd7; key_valid = 1'b1; #1;
    checks++;
    if (key_ready !== 1'b1) begin
      failures++; $display("FAIL basic_ready: got %b expected 1", key_ready);
    end
    tick();
    key_valid = 1'b0; chain_done = 1'b1;
    checks++;
    if ({step_valid, key_ready, pos3, pos2, pos1} !== {2'b00, model_pos()}) begin
      failures++; $display("FAIL basic_step_cycle: got %h expected %h",
        {step_valid, key_ready, pos3, pos2, pos1}, {2'b00, model_pos()});
    end
    tick();
    chain_done = 1'b0;
    model_step(); m_key = 7;
    checks++;
    if ({pos3, pos2, pos1} !== {5'd0, 5'd0, 5'd1}) begin
      failures++; $display("FAIL basic_pos: got %h expected %h", {pos3, pos2, pos1}, {5'd0, 5'd0, 5'd1});
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({step_valid, key_out, pos3, pos2, pos1} !== {1'b1, m_key[4:0], model_pos()}) begin
        failures++; $display("FAIL basic_hold: got %h expected %h",
          {step_valid, key_out, pos3, pos2, pos1}, {1'b1, m_key[4:0], model_pos()});
      end
      tick();
    end
    drive_release();
    checks++;
    if ({step_valid, key_ready} !== 2'b01) begin
      failures++; $display("FAIL basic_release: got %b expected 01", {step_valid, key_ready});
    end
  endtask

  task automatic test_double_step();
    logic [14:0] exp_tab[3];
    exp_tab[0] = {5'd0, 5'd3, 5'd21};
    exp_tab[1] = {5'd0, 5'd4, 5'd22};
    exp_tab[2] = {5'd1, 5'd5, 5'd23};
    load = 1'b1; load_pos1 = 5'd20; load_pos2 = 5'd3; load_pos3 = 5'd0; #1;
    checks++;
    if (key_ready !== 1'b0) begin
      failures++; $display("FAIL load_blocks_ready: got %b expected 0", key_ready);
    end
    tick();
    load = 1'b0;
    model_load(20, 3, 0);
    checks++;
    if ({err, pos3, pos2, pos1} !== {1'b0, 5'd0, 5'd3, 5'd20}) begin
      failures++; $display("FAIL dstep_load: got %h expected %h", {err, pos3, pos2, pos1}, {1'b0, 5'd0, 5'd3, 5'd20});
    end
    for (int i = 0; i < 3; i++) begin
      drive_accept(i + 1);
      model_step(); m_key = i + 1;
      checks++;
      if ({pos3, pos2, pos1} !== exp_tab[i]) begin
        failures++; $display("FAIL dstep_%0d: got %h expected %h", i, {pos3, pos2, pos1}, exp_tab[i]);
      end
      drive_release();
    end
  endtask

  task automatic test_wrap();
    drive_load(25, 25, 25);
    model_load(25, 25, 25);
    drive_accept(0);
    model_step(); m_key = 0;
    checks++;
    if ({pos3, pos2, pos1} !== {5'd25, 5'd25, 5'd0}) begin
      failures++; $display("FAIL wrap: got %h expected %h", {pos3, pos2, pos1}, {5'd25, 5'd25, 5'd0});
    end
    drive_release();
  endtask

  task automatic test_invalid_key();
    key_valid = 1'b1; key_in = 5'd27;
    tick();
    key_valid = 1'b0;
    checks++;
    if ({err, step_valid, key_ready} !== 3'b101) begin
      failures++; $display("FAIL badkey_flags: got %b expected 101", {err, step_valid, key_ready});
    end
    checks++;
    if ({key_out, pos3, pos2, pos1} !== {m_key[4:0], model_pos()}) begin
      failures++; $display("FAIL badkey_regs: got %h expected %h", {key_out, pos3, pos2, pos1}, {m_key[4:0], model_pos()});
    end
    tick();
    checks++;
    if ({err, step_valid} !== 2'b00) begin
      failures++; $display("FAIL badkey_after: got %b expected 00", {err, step_valid});
    end
  endtask

  task automatic test_invalid_load();
    drive_load(30, 5, 31);
    model_load(30, 5, 31);
    checks++;
    if ({err, pos3, pos2, pos1} !== {1'b1, 5'd5, 5'd5, 5'd4}) begin
      failures++; $display("FAIL badload: got %h expected %h", {err, pos3, pos2, pos1}, {1'b1, 5'd5, 5'd5, 5'd4});
    end
    tick();
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL badload_pulse: got %b expected 0", err);
    end
  endtask

  task automatic test_load_in_hold();
    drive_accept(9);
    model_step(); m_key = 9;
    load = 1'b1; load_pos1 = 5'd30; load_pos2 = 5'd1; load_pos3 = 5'd2; #1;
    checks++;
    if (key_ready !== 1'b0) begin
      failures++; $display("FAIL hold_ready: got %b expected 0", key_ready);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({err, step_valid, key_out, pos3, pos2, pos1} !== {2'b01, m_key[4:0], model_pos()}) begin
        failures++; $display("FAIL hold_load_ignored: got %h expected %h",
          {err, step_valid, key_out, pos3, pos2, pos1}, {2'b01, m_key[4:0], model_pos()});
      end
    end
    load = 1'b0;
    drive_release();
  endtask

  task automatic test_load_collision();
    load = 1'b1; key_valid = 1'b1; key_in = 5'd3;
    load_pos1 = 5'd10; load_pos2 = 5'd11; load_pos3 = 5'd12; #1;
    checks++;
    if (key_ready !== 1'b0) begin
      failures++; $display("FAIL coll_ready: got %b expected 0", key_ready);
    end
    tick();
    load = 1'b0; key_valid = 1'b0;
    model_load(10, 11, 12);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({err, step_valid, pos3, pos2, pos1} !== {2'b00, model_pos()}) begin
        failures++; $display("FAIL coll_state: got %h expected %h",
          {err, step_valid, pos3, pos2, pos1}, {2'b00, model_pos()});
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int k;
    chain_done = 1'b1; key_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      k = $urandom_range(0, 25);
      key_in = k[4:0]; #1;
      checks++;
      if (key_ready !== 1'b1) begin
        failures++; $display("FAIL b2b_ready: got %b expected 1", key_ready);
      end
      tick();
      checks++;
      if ({key_ready, step_valid} !== 2'b00) begin
        failures++; $display("FAIL b2b_step: got %b expected 00", {key_ready, step_valid});
      end
      tick();
      model_step(); m_key = k;
      checks++;
      if ({step_valid, key_out, pos3, pos2, pos1} !== {1'b1, m_key[4:0], model_pos()}) begin
        failures++; $display("FAIL b2b_hold: got %h expected %h",
          {step_valid, key_out, pos3, pos2, pos1}, {1'b1, m_key[4:0], model_pos()});
      end
      tick();
    end
    chain_done = 1'b0; key_valid = 1'b0;
  endtask

  task automatic test_random();
    int op, a, b, c, k, hold;
    bit bad;
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      if (op < 3) begin
        a = $urandom_range(0, 31); b = $urandom_range(0, 31); c = $urandom_range(0, 31);
        bad = (a >= 26) || (b >= 26) || (c >= 26);
        drive_load(a, b, c);
        model_load(a, b, c);
        checks++;
        if ({err, pos3, pos2, pos1} !== {bad, model_pos()}) begin
          failures++; $display("FAIL rnd_load: got %h expected %h", {err, pos3, pos2, pos1}, {bad, model_pos()});
        end
      end else begin
        k = $urandom_range(0, 31);
        if (k >= 26) begin
          key_valid = 1'b1; key_in = k[4:0];
          tick();
          key_valid = 1'b0;
          checks++;
          if ({err, key_ready, pos3, pos2, pos1} !== {2'b11, model_pos()}) begin
            failures++; $display("FAIL rnd_badkey: got %h expected %h", {err, key_ready, pos3, pos2, pos1}, {2'b11, model_pos()});
          end
        end else begin
          model_step(); m_key = k;
          exp_q.push_back({m_key[4:0], model_pos()});
          drive_accept(k);
          hold = $urandom_range(0, 3);
          for (int h = 0; h <= hold; h++) begin
            checks++;
            if ({step_valid, key_out, pos3, pos2, pos1} !== {1'b1, exp_q[0]}) begin
              failures++; $display("FAIL rnd_hold: got %h expected %h",
                {step_valid, key_out, pos3, pos2, pos1}, {1'b1, exp_q[0]});
            end
            if (h < hold) tick();
          end
          drive_release();
          void'(exp_q.pop_front());
          checks++;
          if ({step_valid, key_ready} !== 2'b01) begin
            failures++; $display("FAIL rnd_release: got %b expected 01", {step_valid, key_ready});
          end
        end
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_reset_mid_hold();
    drive_accept(5);
    rst_n = 1'b0; #1;
    checks++;
    if ({step_valid, key_ready} !== 2'b00) begin
      failures++; $display("FAIL rst_hold_gate: got %b expected 00", {step_valid, key_ready});
    end
    tick();
    checks++;
    if ({err, step_valid, key_out, pos3, pos2, pos1} !== 22'd0) begin
      failures++; $display("FAIL rst_hold_regs: got %h expected 0", {err, step_valid, key_out, pos3, pos2, pos1});
    end
    rst_n = 1'b1; #1;
    model_reset();
    checks++;
    if (key_ready !== 1'b1) begin
      failures++; $display("FAIL rst_hold_ready: got %b expected 1", key_ready);
    end
    tick();
    drive_accept(2);
    model_step(); m_key = 2;
    checks++;
    if ({key_out, pos3, pos2, pos1} !== {m_key[4:0], model_pos()}) begin
      failures++; $display("FAIL rst_hold_restep: got %h expected %h", {key_out, pos3, pos2, pos1}, {m_key[4:0], model_pos()});
    end
    drive_release();
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; key_valid = 1'b0; chain_done = 1'b0;
    key_in = 5'd0; load_pos1 = 5'd0; load_pos2 = 5'd0; load_pos3 = 5'd0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_basic_step();
    test_double_step();
    test_wrap();
    test_invalid_key();
    test_invalid_load();
    test_load_in_hold();
    test_load_collision();
    test_back_to_back();
    test_random();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
